// File: rtl/stack_op_sequencer_pkg.sv
// Shared definitions for the stack op sequencer: opcodes, FSM states, sizing defaults.
package stack_op_sequencer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH_LOG2 = 8;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h10;
    localparam logic [7:0] OP_PUSH0 = 8'h11;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_INC   = 8'h20;
    localparam logic [7:0] OP_ADD   = 8'h21;
    localparam logic [7:0] OP_BR    = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/stack_op_sequencer_ram.sv
// Single-port stack storage with synchronous read; no reset so it maps onto block RAM.
module stack_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Write port and registered read share the single address.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Data-stack controller: one op per handshake, top item cached in a register,
// remaining items held in stack_ram (item k at address k).
module stack_op_sequencer
    import stack_op_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_op_valid,
    output logic                  o_op_ready,
    input  logic [7:0]            i_op_code,
    input  logic [DATA_WIDTH-1:0] i_op_operand,
    output logic                  o_done,
    output logic                  o_op_error,
    output logic                  o_branch_valid,
    output logic [DATA_WIDTH-1:0] o_branch_target,
    output logic [DATA_WIDTH-1:0] o_top_item,
    output logic                  o_stack_not_empty,
    output logic [DEPTH_LOG2:0]   o_item_count,
    output logic                  o_err_overflow,
    output logic                  o_err_underflow
);

    localparam logic [DEPTH_LOG2:0]   C_FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   C_CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   C_CNT_TWO  = {{(DEPTH_LOG2-1){1'b0}}, 2'b10};
    localparam logic [DEPTH_LOG2-1:0] C_ADDR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] C_ADDR_TWO = {{(DEPTH_LOG2-2){1'b0}}, 2'b10};
    localparam logic [DATA_WIDTH-1:0] C_DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [7:0]            r_code;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_top;
    logic [DATA_WIDTH-1:0] r_branch_target;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_not_empty;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_op_error;
    logic                  r_branch_valid;
    logic                  r_err_overflow;
    logic                  r_err_underflow;

    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DEPTH_LOG2-1:0] w_addr_m1;
    logic [DEPTH_LOG2-1:0] w_addr_m2;

    // Address arithmetic is modulo the RAM size: count==2**DEPTH_LOG2 maps to 0 so count-2 lands on the right slot.
    assign w_addr_m1 = r_count[DEPTH_LOG2-1:0] - C_ADDR_ONE;
    assign w_addr_m2 = r_count[DEPTH_LOG2-1:0] - C_ADDR_TWO;
    assign w_ram_we  = (r_state == ST_WRITE);

    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // Op sequencer: accepts in IDLE, commits all architectural state on the edge entering DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_code          <= 8'h00;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_top           <= '0;
            r_branch_target <= '0;
            r_count         <= '0;
            r_not_empty     <= 1'b0;
            r_ready         <= 1'b1;
            r_done          <= 1'b0;
            r_op_error      <= 1'b0;
            r_branch_valid  <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_op_error     <= 1'b0;
            r_branch_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_op_valid) begin
                        r_code  <= i_op_code;
                        r_ready <= 1'b0;
                        case (i_op_code)
                            OP_PUSH, OP_PUSH0: begin
                                if (r_count == C_FULL) begin
                                    r_state        <= ST_DONE;
                                    r_done         <= 1'b1;
                                    r_op_error     <= 1'b1;
                                    r_err_overflow <= 1'b1;
                                end else begin
                                    r_addr  <= r_count[DEPTH_LOG2-1:0];
                                    r_wdata <= (i_op_code == OP_PUSH) ? i_op_operand : '0;
                                    r_state <= ST_WRITE;
                                end
                            end
                            OP_INC: begin
                                if (r_count == C_CNT_ZERO) begin
                                    r_state         <= ST_DONE;
                                    r_done          <= 1'b1;
                                    r_op_error      <= 1'b1;
                                    r_err_underflow <= 1'b1;
                                end else begin
                                    r_addr  <= w_addr_m1;
                                    r_wdata <= r_top + C_DATA_ONE;
                                    r_state <= ST_WRITE;
                                end
                            end
                            OP_POP, OP_BR: begin
                                if (r_count == C_CNT_ZERO) begin
                                    r_state         <= ST_DONE;
                                    r_done          <= 1'b1;
                                    r_op_error      <= 1'b1;
                                    r_err_underflow <= 1'b1;
                                end else if (r_count == C_CNT_ONE) begin
                                    // Last item lives only in the top register: no RAM access needed.
                                    r_state     <= ST_DONE;
                                    r_done      <= 1'b1;
                                    r_top       <= '0;
                                    r_count     <= C_CNT_ZERO;
                                    r_not_empty <= 1'b0;
                                    if (i_op_code == OP_BR) begin
                                        r_branch_target <= r_top;
                                        r_branch_valid  <= 1'b1;
                                    end else begin
                                        r_branch_valid  <= 1'b0;
                                    end
                                end else begin
                                    r_addr  <= w_addr_m2;
                                    r_state <= ST_RD_ISSUE;
                                end
                            end
                            OP_ADD: begin
                                if (r_count < C_CNT_TWO) begin
                                    r_state         <= ST_DONE;
                                    r_done          <= 1'b1;
                                    r_op_error      <= 1'b1;
                                    r_err_underflow <= 1'b1;
                                end else begin
                                    r_addr  <= w_addr_m2;
                                    r_state <= ST_RD_ISSUE;
                                end
                            end
                            OP_NOP: begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                            default: begin
                                r_state    <= ST_DONE;
                                r_done     <= 1'b1;
                                r_op_error <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (r_code == OP_ADD) begin
                        r_wdata <= r_top + w_rdata;
                        r_state <= ST_WRITE;
                    end else begin
                        r_top       <= w_rdata;
                        r_count     <= r_count - C_CNT_ONE;
                        r_not_empty <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                        if (r_code == OP_BR) begin
                            r_branch_target <= r_top;
                            r_branch_valid  <= 1'b1;
                        end else begin
                            r_branch_valid  <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    r_top       <= r_wdata;
                    r_not_empty <= 1'b1;
                    r_done      <= 1'b1;
                    r_state     <= ST_DONE;
                    if (r_code == OP_ADD) begin
                        r_count <= r_count - C_CNT_ONE;
                    end else if (r_code == OP_INC) begin
                        r_count <= r_count;
                    end else begin
                        r_count <= r_count + C_CNT_ONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_op_ready        = r_ready;
    assign o_done            = r_done;
    assign o_op_error        = r_op_error;
    assign o_branch_valid    = r_branch_valid;
    assign o_branch_target   = r_branch_target;
    assign o_top_item        = r_top;
    assign o_stack_not_empty = r_not_empty;
    assign o_item_count      = r_count;
    assign o_err_overflow    = r_err_overflow;
    assign o_err_underflow   = r_err_underflow;

endmodule
